// File: rtl/mem_stage_access.sv
// MEM-stage data-memory access: request FSM, stall generation, store lane alignment,
// load extension and the MEM/WB register. Optional macro MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage_access #(
  parameter int RESP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_valid,
  input  logic [31:0] MEM_pc,
  input  logic [31:0] MEM_alu_out,
  input  logic [31:0] MEM_rs2_out,
  input  logic        MEM_cmp_out,
  input  logic        MEM_mem_read,
  input  logic        MEM_mem_write,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  output logic        mem_stall,
  output logic        WB_valid,
  output logic [31:0] WB_pc,
  output logic [31:0] WB_alu_out,
  output logic        WB_cmp_out,
  output logic [31:0] WB_rdata,
  output logic        WB_fault
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;
  localparam int CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          read_q, read_d, write_q, write_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    offs_q, offs_d;
  logic          wb_valid_q, wb_valid_d, wb_cmp_q, wb_cmp_d, wb_fault_q, wb_fault_d;
  logic [31:0]   wb_pc_q, wb_pc_d, wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d;

  logic        req, is_read, is_write, misaligned, in_access, timeout, stall;
  logic [1:0]  a;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, rdata_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign a         = MEM_alu_out[1:0];
  assign req       = MEM_valid & (MEM_mem_read | MEM_mem_write);
  assign is_read   = MEM_mem_read;
  assign is_write  = MEM_mem_write & ~MEM_mem_read;
  assign in_access = (state_q == S_ACCESS);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  always_comb begin
    case (MEM_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  generate
    if (RESP_TIMEOUT > 0) begin : g_timeout
      // Fires in the Nth response-less ACCESS cycle so the strobe lasts exactly N cycles.
      assign timeout = in_access & (cnt_q == CW'(RESP_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  always_comb begin
    be_new    = 4'hF;
    wdata_new = MEM_rs2_out;
    if (is_write) begin
      case (MEM_funct3[1:0])
        2'b00: begin
          be_new    = 4'b0001 << a;
          wdata_new = {4{MEM_rs2_out[7:0]}};
        end
        2'b01: begin
          be_new    = 4'b0011 << {a[1], 1'b0};
          wdata_new = {2{MEM_rs2_out[15:0]}};
        end
        default: begin
          be_new    = 4'hF;
          wdata_new = MEM_rs2_out;
        end
      endcase
    end
  end

  always_comb begin
    case (offs_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = offs_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  rdata_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  rdata_ext = {24'h0, ld_byte};
      3'b001:  rdata_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  rdata_ext = {16'h0, ld_half};
      default: rdata_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    read_d   = read_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    funct3_d = funct3_q;
    offs_d   = offs_q;
    stall    = 1'b0;
    if (!in_access) begin
      if (req && !misaligned) begin
        state_d  = S_ACCESS;
        cnt_d    = '0;
        read_d   = is_read;
        write_d  = is_write;
        addr_d   = {MEM_alu_out[31:2], 2'b00};
        wdata_d  = wdata_new;
        be_d     = be_new;
        funct3_d = MEM_funct3;
        offs_d   = a;
        stall    = 1'b1;
      end
    end else if (dmem_resp || timeout) begin
      state_d = S_IDLE;
      read_d  = 1'b0;
      write_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
      stall = 1'b1;
    end
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_pc_d    = wb_pc_q;
    wb_alu_d   = wb_alu_q;
    wb_cmp_d   = wb_cmp_q;
    wb_rdata_d = wb_rdata_q;
    wb_fault_d = wb_fault_q;
    if (!stall) begin
      wb_valid_d = MEM_valid;
      wb_pc_d    = MEM_pc;
      wb_alu_d   = MEM_alu_out;
      wb_cmp_d   = MEM_cmp_out;
      wb_rdata_d = '0;
      wb_fault_d = 1'b0;
      // An unstalled ACCESS cycle means either a response or a timeout; response wins.
      if (in_access) begin
        if (dmem_resp) begin
          if (read_q) wb_rdata_d = rdata_ext;
        end else begin
          wb_fault_d = 1'b1;
        end
      end else if (req && misaligned) begin
        wb_fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      funct3_q   <= '0;
      offs_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_pc_q    <= '0;
      wb_alu_q   <= '0;
      wb_cmp_q   <= 1'b0;
      wb_rdata_q <= '0;
      wb_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      read_q     <= read_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      funct3_q   <= funct3_d;
      offs_q     <= offs_d;
      wb_valid_q <= wb_valid_d;
      wb_pc_q    <= wb_pc_d;
      wb_alu_q   <= wb_alu_d;
      wb_cmp_q   <= wb_cmp_d;
      wb_rdata_q <= wb_rdata_d;
      wb_fault_q <= wb_fault_d;
    end
  end

  assign dmem_read        = read_q;
  assign dmem_write       = write_q;
  assign dmem_address     = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_byte_enable = be_q;
  assign mem_stall        = stall;
  assign WB_valid         = wb_valid_q;
  assign WB_pc            = wb_pc_q;
  assign WB_alu_out       = wb_alu_q;
  assign WB_cmp_out       = wb_cmp_q;
  assign WB_rdata         = wb_rdata_q;
  assign WB_fault         = wb_fault_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access (RESP_TIMEOUT=4): transaction-level expectation model checked
// every cycle, plus directed literal checks. Honours MEM_STAGE_MISALIGN_TRAP_EN if defined.
module tb_mem_stage_access;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_valid, MEM_cmp_out, MEM_mem_read, MEM_mem_write;
  logic [31:0] MEM_pc, MEM_alu_out, MEM_rs2_out;
  logic [2:0]  MEM_funct3;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read, dmem_write, mem_stall;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic        WB_valid, WB_cmp_out, WB_fault;
  logic [31:0] WB_pc, WB_alu_out, WB_rdata;

  mem_stage_access #(.RESP_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MEM_valid(MEM_valid), .MEM_pc(MEM_pc), .MEM_alu_out(MEM_alu_out),
    .MEM_rs2_out(MEM_rs2_out), .MEM_cmp_out(MEM_cmp_out),
    .MEM_mem_read(MEM_mem_read), .MEM_mem_write(MEM_mem_write), .MEM_funct3(MEM_funct3),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .mem_stall(mem_stall),
    .WB_valid(WB_valid), .WB_pc(WB_pc), .WB_alu_out(WB_alu_out), .WB_cmp_out(WB_cmp_out),
    .WB_rdata(WB_rdata), .WB_fault(WB_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Expected outputs for the current cycle, maintained by the driver.
  logic        e_stall = 1'b0, e_read = 1'b0, e_write = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [3:0]  e_be = '0;
  logic        e_wb_valid = 1'b0, e_wb_cmp = 1'b0, e_wb_fault = 1'b0;
  logic [31:0] e_wb_pc = '0, e_wb_alu = '0, e_wb_rdata = '0;

  // Per-operation observations gathered by the compare process.
  int          n_stall = 0, n_strobe = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [3:0]  last_be = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_misaligned(input logic [2:0] f3, input logic [1:0] a);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b00) return 1'b0;
    if (f3[1:0] == 2'b01) return a[0];
    return a != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_be(input logic store, input logic [2:0] f3, input logic [1:0] a);
    int sh;
    if (!store) return 4'hF;
    if (f3[1:0] == 2'b00) begin
      sh = a;
      return 4'(1 << sh);
    end
    if (f3[1:0] == 2'b01) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    if (f3[1:0] == 2'b00) return (rs2 & 32'hFF) * 32'h01010101;
    if (f3[1:0] == 2'b01) return (rs2 & 32'hFFFF) * 32'h00010001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v;
    int sh;
    sh = a;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * sh)) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        v = (w >> (16 * (sh / 2))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_stall", {31'b0, mem_stall}, {31'b0, e_stall});
      chk("dmem_read", {31'b0, dmem_read}, {31'b0, e_read});
      chk("dmem_write", {31'b0, dmem_write}, {31'b0, e_write});
      if (e_read || e_write) begin
        chk("dmem_address", dmem_address, e_addr);
        chk("dmem_byte_enable", {28'b0, dmem_byte_enable}, {28'b0, e_be});
        if (e_write) chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      chk("WB_valid", {31'b0, WB_valid}, {31'b0, e_wb_valid});
      chk("WB_pc", WB_pc, e_wb_pc);
      chk("WB_alu_out", WB_alu_out, e_wb_alu);
      chk("WB_cmp_out", {31'b0, WB_cmp_out}, {31'b0, e_wb_cmp});
      chk("WB_rdata", WB_rdata, e_wb_rdata);
      chk("WB_fault", {31'b0, WB_fault}, {31'b0, e_wb_fault});
      if (mem_stall) n_stall++;
      if (dmem_read || dmem_write) begin
        n_strobe++;
        last_addr  = dmem_address;
        last_be    = dmem_byte_enable;
        last_wdata = dmem_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                        input logic cmp, input logic [31:0] rd, input logic flt);
    e_wb_valid = v; e_wb_pc = pc; e_wb_alu = alu; e_wb_cmp = cmp;
    e_wb_rdata = rd; e_wb_fault = flt;
  endtask

  // One MEM-stage instruction from presentation to WB. resp_at = ACCESS cycle of the
  // response (0 = never); rst_at = ACCESS cycle in which reset is asserted (0 = none).
  task automatic op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] pc,
                    input logic cmp, input logic [31:0] rdata, input int resp_at,
                    input logic stray, input int rst_at);
    logic req, mis, got;
    req = v & (rd | wr);
    mis = req & m_misaligned(f3, addr[1:0]);
    n_stall = 0;
    n_strobe = 0;
    MEM_valid = v; MEM_mem_read = rd; MEM_mem_write = wr; MEM_funct3 = f3;
    MEM_alu_out = addr; MEM_rs2_out = rs2; MEM_pc = pc; MEM_cmp_out = cmp;
    dmem_resp = stray;
    dmem_rdata = $urandom;
    e_stall = req & ~mis; e_read = 1'b0; e_write = 1'b0;
    step();
    if (!(req && !mis)) begin
      dmem_resp = 1'b0;
      set_wb(v, pc, addr, cmp, 32'h0, mis);
      return;
    end
    got = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      e_read = rd; e_write = wr & ~rd;
      e_addr = addr & 32'hFFFF_FFFC;
      e_be = m_be(wr & ~rd, f3, addr[1:0]);
      e_wdata = m_wdata(f3, rs2);
      got = (k == resp_at);
      dmem_resp = got;
      dmem_rdata = got ? rdata : $urandom;
      e_stall = !got && (k != TO);
      if (k == rst_at) begin
        reset = 1'b1;
        MEM_valid = 1'b0;
      end
      step();
      if (k == rst_at) begin
        reset = 1'b0;
        dmem_resp = 1'b0;
        e_read = 1'b0; e_write = 1'b0; e_stall = 1'b0;
        set_wb(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        return;
      end
      if (got || k == TO) break;
    end
    dmem_resp = 1'b0;
    e_read = 1'b0; e_write = 1'b0;
    set_wb(v, pc, addr, cmp, (got && rd) ? m_ext(f3, addr[1:0], rdata) : 32'h0, !got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    MEM_valid = 1'b0; MEM_mem_read = 1'b0; MEM_mem_write = 1'b0; MEM_funct3 = 3'b010;
    MEM_pc = '0; MEM_alu_out = '0; MEM_rs2_out = '0; MEM_cmp_out = 1'b0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_WB_valid", {31'b0, WB_valid}, 32'h0);
    chk("reset_dmem_read", {31'b0, dmem_read}, 32'h0);

    // LW 0x100, response one cycle after the first strobe
    op(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'h1000, 0, 32'hDEADBEEF, 2, 0, 0);
    $display("txn LW  0x100 -> WB_rdata=%08h stall=%0d", WB_rdata, n_stall);
    chk("t1_stall_cycles", n_stall, 2);
    chk("t1_strobe_cycles", n_strobe, 2);
    chk("t1_rdata", WB_rdata, 32'hDEADBEEF);

    // SB 0x103
    op(1, 0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h1004, 1, 32'h0, 1, 0, 0);
    $display("txn SB  0x103 -> be=%b wdata=%08h", last_be, last_wdata);
    chk("t2_be", {28'b0, last_be}, 32'h8);
    chk("t2_wdata", last_wdata, 32'hA5A5A5A5);
    chk("t2_addr", last_addr, 32'h100);
    chk("t2_strobe_cycles", n_strobe, 1);

    // Load extension at 0x102
    op(1, 1, 0, 3'b000, 32'h102, 32'h0, 32'h1008, 0, 32'h00800000, 1, 0, 0);
    $display("txn LB  0x102 -> %08h", WB_rdata);
    chk("t3_lb", WB_rdata, 32'hFFFFFF80);
    op(1, 1, 0, 3'b100, 32'h102, 32'h0, 32'h100C, 0, 32'h00800000, 1, 0, 0);
    $display("txn LBU 0x102 -> %08h", WB_rdata);
    chk("t3_lbu", WB_rdata, 32'h00000080);
    op(1, 1, 0, 3'b001, 32'h102, 32'h0, 32'h1010, 0, 32'h00800000, 1, 0, 0);
    $display("txn LH  0x102 -> %08h", WB_rdata);
    chk("t3_lh", WB_rdata, 32'h00000080);
    op(1, 1, 0, 3'b001, 32'h102, 32'h0, 32'h1014, 0, 32'h80000000, 3, 0, 0);
    $display("txn LH  0x102 -> %08h", WB_rdata);
    chk("t3_lh_neg", WB_rdata, 32'hFFFF8000);
    op(1, 1, 0, 3'b101, 32'h102, 32'h0, 32'h1018, 0, 32'h80000000, 1, 0, 0);
    $display("txn LHU 0x102 -> %08h", WB_rdata);
    chk("t3_lhu", WB_rdata, 32'h00008000);

    // SH / SW / read+write / undefined funct3
    op(1, 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h101C, 0, 32'h0, 2, 0, 0);
    $display("txn SH  0x102 -> be=%b wdata=%08h", last_be, last_wdata);
    chk("sh_be", {28'b0, last_be}, 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);
    op(1, 0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h1020, 1, 32'h0, 1, 0, 0);
    $display("txn SW  0x104 -> be=%b wdata=%08h", last_be, last_wdata);
    chk("sw_wdata", last_wdata, 32'hCAFEF00D);
    op(1, 1, 1, 3'b010, 32'h108, 32'h77777777, 32'h1024, 0, 32'h01020304, 1, 0, 0);
    $display("txn LW+SW 0x108 -> %08h", WB_rdata);
    chk("rw_rdata", WB_rdata, 32'h01020304);
    op(1, 1, 0, 3'b011, 32'h10C, 32'h0, 32'h1028, 0, 32'h87654321, 1, 0, 0);
    $display("txn LD? 0x10C -> %08h", WB_rdata);
    chk("undef_f3", WB_rdata, 32'h87654321);

    // Non-memory instruction with a stray response
    op(1, 0, 0, 3'b000, 32'h12345678, 32'h0, 32'h2000, 1, 32'h0, 0, 1, 0);
    $display("txn ALU -> WB_alu_out=%08h", WB_alu_out);
    chk("alu_pass", WB_alu_out, 32'h12345678);
    chk("alu_stall", n_stall, 0);

    // Timeout, then response coinciding with timeout
    op(1, 1, 0, 3'b010, 32'h200, 32'h0, 32'h3000, 0, 32'h0, 0, 0, 0);
    $display("txn LW  0x200 timeout -> fault=%0b strobes=%0d", WB_fault, n_strobe);
    chk("to_strobe_cycles", n_strobe, 4);
    chk("to_fault", {31'b0, WB_fault}, 32'h1);
    chk("to_rdata", WB_rdata, 32'h0);
    op(1, 1, 0, 3'b010, 32'h204, 32'h0, 32'h3004, 0, 32'h55AA55AA, TO, 0, 0);
    $display("txn LW  0x204 late resp -> fault=%0b rdata=%08h", WB_fault, WB_rdata);
    chk("to_resp_fault", {31'b0, WB_fault}, 32'h0);
    chk("to_resp_rdata", WB_rdata, 32'h55AA55AA);

    // Reset in the second ACCESS cycle
    op(1, 1, 0, 3'b010, 32'h300, 32'h0, 32'h4000, 1, 32'h0, 0, 0, 2);
    $display("txn LW  0x300 reset -> WB_pc=%08h", WB_pc);
    chk("rst_read", {31'b0, dmem_read}, 32'h0);
    chk("rst_stall", {31'b0, mem_stall}, 32'h0);
    chk("rst_wb_pc", WB_pc, 32'h0);
    chk("rst_wb_valid", {31'b0, WB_valid}, 32'h0);

    // Misaligned word load
    op(1, 1, 0, 3'b010, 32'h102, 32'h0, 32'h5000, 0, 32'h11223344, 1, 0, 0);
    $display("txn LW  0x102 -> fault=%0b rdata=%08h", WB_fault, WB_rdata);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    chk("mis_strobes", n_strobe, 0);
    chk("mis_stall", n_stall, 0);
    chk("mis_fault", {31'b0, WB_fault}, 32'h1);
`else
    chk("mis_addr", last_addr, 32'h100);
    chk("mis_fault", {31'b0, WB_fault}, 32'h0);
    chk("mis_rdata", WB_rdata, 32'h11223344);
`endif
    op(1, 0, 1, 3'b001, 32'h101, 32'h0000BEEF, 32'h5004, 0, 32'h0, 1, 0, 0);
    $display("txn SH  0x101 -> fault=%0b be=%b", WB_fault, last_be);

    op(0, 0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);
    op(0, 0, 0, 3'b010, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
